wb_async_sram_ctrl: RTL and testbench

Wishbone classic-cycle slave that drives a bank of x8 asynchronous SRAM chips. The target parts are 128Kx8-class devices, with one chip per byte lane. Read and write timing is set by parameters as whole clock cycles, so every tRC/tWC/tPWE/tSD/tHZWE budget is met by construction. Sits between the wb interconnect and the board SRAM (or the testbench SRAM models), replacing ad-hoc per-design SRAM glue.

---
 rtl/wb_async_sram_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_wb_async_sram_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_async_sram_ctrl.sv
// rtl/wb_async_sram_ctrl.sv - Wishbone classic slave for a bank of x8 asynchronous SRAMs
// Every SRAM strobe is registered and timed in whole clock cycles by one shared down-counter.
module wb_async_sram_ctrl #(
   parameter int DW       = 32,
   parameter int AW       = 17,
   parameter int RD_WAIT  = 1,
   parameter int WR_SETUP = 1,
   parameter int WR_PULSE = 2,
   parameter int WR_HOLD  = 1,
   parameter int TURN     = 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              wb_cyc_i,
   input  logic              wb_stb_i,
   input  logic              wb_we_i,
   input  logic [31:0]       wb_adr_i,
   input  logic [DW/8-1:0]   wb_sel_i,
   input  logic [DW-1:0]     wb_dat_i,
   output logic [DW-1:0]     wb_dat_o,
   output logic              wb_ack_o,
   output logic [AW-1:0]     sram_adr_o,
   output logic [DW-1:0]     sram_dat_o,
   input  logic [DW-1:0]     sram_dat_i,
   output logic              sram_dat_oe_o,
   output logic [DW/8-1:0]   sram_ce_n_o,
   output logic              sram_oe_n_o,
   output logic              sram_we_n_o
);
   localparam int NL = DW / 8;
   localparam int LS = $clog2(NL);
   localparam logic [3:0] RD_CNT = 4'(RD_WAIT);
   localparam logic [3:0] SU_CNT = 4'((WR_SETUP > 0) ? WR_SETUP - 1 : 0);
   localparam logic [3:0] PL_CNT = 4'((WR_PULSE > 0) ? WR_PULSE - 1 : 0);
   localparam logic [3:0] HD_CNT = 4'((WR_HOLD > 0) ? WR_HOLD - 1 : 0);
   // The ack cycle always sits in TURN, so TURN = 0 still spends one cycle there.
   localparam logic [3:0] TN_CNT = 4'((TURN > 0) ? TURN - 1 : 0);

   if (DW < 8 || DW % 8 != 0) begin : g_bad_dw
      $error("wb_async_sram_ctrl: DW must be a nonzero multiple of 8");
   end
   if (AW < 1 || AW + LS > 32) begin : g_bad_aw
      $error("wb_async_sram_ctrl: AW out of range");
   end
   if (RD_WAIT < 0 || RD_WAIT > 14) begin : g_bad_rd
      $error("wb_async_sram_ctrl: RD_WAIT must be 0..14");
   end
   if (WR_SETUP < 0 || WR_SETUP > 15) begin : g_bad_su
      $error("wb_async_sram_ctrl: WR_SETUP must be 0..15");
   end
   if (WR_PULSE < 1 || WR_PULSE > 15) begin : g_bad_pl
      $error("wb_async_sram_ctrl: WR_PULSE must be 1..15");
   end
   if (WR_HOLD < 0 || WR_HOLD > 15) begin : g_bad_hd
      $error("wb_async_sram_ctrl: WR_HOLD must be 0..15");
   end
   if (TURN < 0 || TURN > 15) begin : g_bad_tn
      $error("wb_async_sram_ctrl: TURN must be 0..15");
   end

   typedef enum logic [2:0] {S_IDLE, S_RD, S_WSU, S_WPL, S_WHD, S_TURN} state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            ack_q, ack_d;
   logic [DW-1:0]   rdat_q, rdat_d;
   logic [AW-1:0]   adr_q, adr_d;
   logic [DW-1:0]   dat_q, dat_d;
   logic            doe_q, doe_d;
   logic [NL-1:0]   ce_n_q, ce_n_d;
   logic            oe_n_q, oe_n_d;
   logic            we_n_q, we_n_d;
   logic            wr_done;
   logic            unused_adr;

   assign unused_adr = ^wb_adr_i;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q - 4'd1;
      ack_d   = 1'b0;
      rdat_d  = rdat_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      doe_d   = doe_q;
      ce_n_d  = ce_n_q;
      oe_n_d  = oe_n_q;
      we_n_d  = we_n_q;
      wr_done = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = cnt_q;
            if (wb_cyc_i && wb_stb_i) begin
               adr_d = wb_adr_i[AW+LS-1:LS];
               if (wb_we_i) begin
                  ce_n_d = ~wb_sel_i;
                  doe_d  = 1'b1;
                  dat_d  = wb_dat_i;
                  if (WR_SETUP == 0) begin
                     state_d = S_WPL;
                     we_n_d  = 1'b0;
                     cnt_d   = PL_CNT;
                  end else begin
                     state_d = S_WSU;
                     cnt_d   = SU_CNT;
                  end
               end else begin
                  state_d = S_RD;
                  cnt_d   = RD_CNT;
                  ce_n_d  = '0;
                  oe_n_d  = 1'b0;
               end
            end
         end
         S_RD: if (cnt_q == 4'd0) begin
            rdat_d  = sram_dat_i;
            ack_d   = wb_cyc_i;
            ce_n_d  = '1;
            oe_n_d  = 1'b1;
            state_d = S_TURN;
            cnt_d   = TN_CNT;
         end
         S_WSU: if (cnt_q == 4'd0) begin
            we_n_d  = 1'b0;
            state_d = S_WPL;
            cnt_d   = PL_CNT;
         end
         S_WPL: if (cnt_q == 4'd0) begin
            we_n_d = 1'b1;
            if (WR_HOLD == 0) begin
               wr_done = 1'b1;
            end else begin
               state_d = S_WHD;
               cnt_d   = HD_CNT;
            end
         end
         S_WHD: if (cnt_q == 4'd0) wr_done = 1'b1;
         S_TURN: if (cnt_q == 4'd0) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // A dropped cyc only silences the ack; the SRAM cycle itself always runs to completion.
      if (wr_done) begin
         ack_d   = wb_cyc_i;
         ce_n_d  = '1;
         doe_d   = 1'b0;
         state_d = S_TURN;
         cnt_d   = TN_CNT;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         ack_q   <= 1'b0;
         rdat_q  <= '0;
         adr_q   <= '0;
         dat_q   <= '0;
         doe_q   <= 1'b0;
         ce_n_q  <= '1;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         rdat_q  <= rdat_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         doe_q   <= doe_d;
         ce_n_q  <= ce_n_d;
         oe_n_q  <= oe_n_d;
         we_n_q  <= we_n_d;
      end
   end

   assign wb_dat_o      = rdat_q;
   assign wb_ack_o      = ack_q;
   assign sram_adr_o    = adr_q;
   assign sram_dat_o    = dat_q;
   assign sram_dat_oe_o = doe_q;
   assign sram_ce_n_o   = ce_n_q;
   assign sram_oe_n_o   = oe_n_q;
   assign sram_we_n_o   = we_n_q;
endmodule

// File: tb/tb_wb_async_sram_ctrl.sv
// tb/tb_wb_async_sram_ctrl.sv - self-checking bench for wb_async_sram_ctrl
// A per-access timeline model predicts every strobe cycle by cycle; a scoreboard predicts read data.
module tb_wb_async_sram_ctrl;
   localparam int R = 1, S = 1, P = 2, H = 1, T = 1;
   localparam int TM = (T == 0) ? 1 : T;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        cyc = 0, stb = 0, we = 0;
   logic [31:0] adr = 0, wdat = 0;
   logic [3:0]  sel = 0;
   logic [31:0] wb_dat_o, sram_dat_o, sram_dat_i;
   logic        wb_ack_o, sram_dat_oe, sram_oe_n, sram_we_n;
   logic [16:0] sram_adr;
   logic [3:0]  sram_ce_n;

   wb_async_sram_ctrl #(.DW(32), .AW(17), .RD_WAIT(R), .WR_SETUP(S), .WR_PULSE(P),
                        .WR_HOLD(H), .TURN(T)) dut (
      .clk_i(clk), .rst_ni(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
      .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(wdat), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
      .sram_adr_o(sram_adr), .sram_dat_o(sram_dat_o), .sram_dat_i(sram_dat_i),
      .sram_dat_oe_o(sram_dat_oe), .sram_ce_n_o(sram_ce_n), .sram_oe_n_o(sram_oe_n),
      .sram_we_n_o(sram_we_n));

   // Bank of four x8 SRAMs, one per lane.
   logic [31:0] mem [0:(1<<17)-1];
   always_comb begin
      sram_dat_i = '0;
      if (!sram_oe_n)
         for (int l = 0; l < 4; l++)
            if (!sram_ce_n[l]) sram_dat_i[8*l +: 8] = mem[sram_adr][8*l +: 8];
   end
   always @(posedge clk)
      if (!sram_we_n)
         for (int l = 0; l < 4; l++)
            if (!sram_ce_n[l]) mem[sram_adr][8*l +: 8] <= sram_dat_o[8*l +: 8];

   // Narrow instance: DW = 16, AW = 10.
   logic        x_cyc = 0, x_stb = 0, x_we = 0;
   logic [31:0] x_adr = 0;
   logic [1:0]  x_sel = 0, x_ce_n;
   logic [15:0] x_wdat = 0, x_dat_o, x_sdat_o, x_sdat_i;
   logic        x_ack, x_doe, x_oe_n, x_we_n;
   logic [9:0]  x_sadr;
   logic [15:0] mem16 [0:1023];

   wb_async_sram_ctrl #(.DW(16), .AW(10)) dut16 (
      .clk_i(clk), .rst_ni(rst_n), .wb_cyc_i(x_cyc), .wb_stb_i(x_stb), .wb_we_i(x_we),
      .wb_adr_i(x_adr), .wb_sel_i(x_sel), .wb_dat_i(x_wdat), .wb_dat_o(x_dat_o), .wb_ack_o(x_ack),
      .sram_adr_o(x_sadr), .sram_dat_o(x_sdat_o), .sram_dat_i(x_sdat_i),
      .sram_dat_oe_o(x_doe), .sram_ce_n_o(x_ce_n), .sram_oe_n_o(x_oe_n), .sram_we_n_o(x_we_n));

   always_comb begin
      x_sdat_i = '0;
      if (!x_oe_n)
         for (int l = 0; l < 2; l++)
            if (!x_ce_n[l]) x_sdat_i[8*l +: 8] = mem16[x_sadr][8*l +: 8];
   end
   always @(posedge clk)
      if (!x_we_n)
         for (int l = 0; l < 2; l++)
            if (!x_ce_n[l]) mem16[x_sadr][8*l +: 8] <= x_sdat_o[8*l +: 8];

   int n_chk = 0, n_fail = 0;
   int cyc_n = 0;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   // Current access: kind 0 none, 1 read, 2 write; e0 = cycle count after the accepting edge.
   int          m_kind = 0, m_e0 = 0, m_end = 0, next_free = 0, last_ack = -1;
   logic [3:0]  m_sel = 0;
   logic [16:0] m_adr = 0;
   logic [31:0] m_wdat = 0, m_rdat = 0;
   logic        m_cyc_ok = 1;
   logic [31:0] sb [logic [16:0]];

   always @(negedge clk) if (rst_n) begin
      int d;
      logic [3:0] e_ce;
      logic e_oe_n, e_we_n, e_doe, e_ack;
      d = cyc_n - m_e0;
      e_ce = 4'hF; e_oe_n = 1; e_we_n = 1; e_doe = 0; e_ack = 0;
      if (m_kind == 2 && d >= 0 && d < S + P + H) begin
         e_ce   = ~m_sel;
         e_doe  = 1;
         e_we_n = !(d >= S && d < S + P);
         chk("wr_adr", sram_adr, m_adr);
         chk("wr_dat", sram_dat_o, m_wdat);
      end else if (m_kind == 1 && d >= 0 && d <= R) begin
         e_ce   = 4'h0;
         e_oe_n = 0;
         chk("rd_adr", sram_adr, m_adr);
      end
      if (m_kind != 0 && cyc_n == m_end) e_ack = m_cyc_ok;
      chk("ack", wb_ack_o, e_ack);
      chk("ce_n", sram_ce_n, e_ce);
      chk("oe_n", sram_oe_n, e_oe_n);
      chk("we_n", sram_we_n, e_we_n);
      chk("dat_oe", sram_dat_oe, e_doe);
      chk("oe_vs_doe", !(!sram_oe_n && sram_dat_oe), 1'b1);
      if (m_kind == 1 && cyc_n == m_end && m_cyc_ok) chk("rd_data", wb_dat_o, m_rdat);
      if (wb_ack_o) last_ack = cyc_n;
   end

   // mode 0: normal, 1: drop cyc during setup, 2: async reset in first WE-low cycle
   task automatic access(input logic w_en, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] dt, input int mode, output logic [31:0] rd);
      logic [16:0] w;
      w = a[18:2];
      rd = '0;
      while (cyc_n < next_free) @(negedge clk);
      cyc = 1; stb = 1; we = w_en; adr = a; sel = s; wdat = dt;
      m_e0 = cyc_n + 1; m_kind = w_en ? 2 : 1; m_sel = s; m_adr = w; m_wdat = dt; m_cyc_ok = 1;
      m_end = m_e0 + (w_en ? S + P + H : R + 1);
      m_rdat = sb.exists(w) ? sb[w] : 32'h0;
      next_free = m_end + TM;
      if (mode == 1) begin
         @(negedge clk);
         cyc = 0; stb = 0; m_cyc_ok = 0;
      end
      if (mode == 2) begin
         while (cyc_n < m_e0 + S) @(negedge clk);
         #2 rst_n = 0; cyc = 0; stb = 0; m_kind = 0;
         #1;
         chk("rst_we_n", sram_we_n, 1'b1);
         chk("rst_ce_n", sram_ce_n, 4'hF);
         chk("rst_oe_n", sram_oe_n, 1'b1);
         chk("rst_ack", wb_ack_o, 1'b0);
         @(negedge clk);
         #2 rst_n = 1;
         @(negedge clk);
         chk("post_rst_ack", wb_ack_o, 1'b0);
         next_free = cyc_n;
      end else begin
         while (cyc_n < m_end) @(negedge clk);
         cyc = 0; stb = 0; we = 0;
         rd = wb_dat_o;
         if (w_en) begin
            if (!sb.exists(w)) sb[w] = 32'h0;
            for (int l = 0; l < 4; l++)
               if (s[l]) sb[w][8*l +: 8] = dt[8*l +: 8];
         end
      end
   endtask

   task automatic acc16(input logic w_en, input logic [31:0] a, input logic [1:0] s,
                        input logic [15:0] dt, output logic [15:0] rd, output int lat);
      x_cyc = 1; x_stb = 1; x_we = w_en; x_adr = a; x_sel = s; x_wdat = dt;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!x_ack && lat < 20);
      x_cyc = 0; x_stb = 0; x_we = 0;
      rd = x_dat_o;
      @(negedge clk);
      chk("x_ack_width", x_ack, 1'b0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc_n);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic [15:0] rd16;
      int lat;
      repeat (3) @(negedge clk);
      chk("reset_ack", wb_ack_o, 1'b0);
      chk("reset_ce_n", sram_ce_n, 4'hF);
      chk("reset_we_n", sram_we_n, 1'b1);
      chk("reset_dat_o", wb_dat_o, 32'h0);
      rst_n = 1;
      next_free = cyc_n;

      access(1, 32'h40, 4'hF, 32'hDEADBEEF, 0, rd);
      @(negedge clk);
      chk("wr_ack_latency", last_ack - m_e0, 4);
      access(0, 32'h40, 4'hF, 32'h0, 0, rd);
      @(negedge clk);
      chk("rd_ack_latency", last_ack - m_e0, 2);
      chk("rd_deadbeef", rd, 32'hDEADBEEF);

      access(1, 32'h40, 4'h2, 32'h0000AA00, 0, rd);
      access(0, 32'h40, 4'h0, 32'h0, 0, rd);
      chk("rd_byte_merge", rd, 32'hDEADAAEF);
      access(0, 32'h8008_0043, 4'h5, 32'h0, 0, rd);
      chk("rd_alias", rd, 32'hDEADAAEF);
      access(1, 32'h40, 4'h0, 32'h12345678, 0, rd);
      access(0, 32'h40, 4'hF, 32'h0, 0, rd);
      chk("rd_after_sel0", rd, 32'hDEADAAEF);

      access(1, 32'h44, 4'hF, 32'hCAFEF00D, 1, rd);
      access(0, 32'h44, 4'hF, 32'h0, 0, rd);
      chk("rd_after_cyc_drop", rd, 32'hCAFEF00D);

      access(1, 32'h48, 4'hF, 32'h11111111, 2, rd);
      access(1, 32'h4C, 4'hF, 32'h5A5AA5A5, 0, rd);
      access(0, 32'h4C, 4'hF, 32'h0, 0, rd);
      chk("rd_after_reset", rd, 32'h5A5AA5A5);

      for (int i = 0; i < 8; i++) access(1, (32'h100 + i) << 2, 4'hF, $urandom, 0, rd);
      for (int i = 0; i < 300; i++) begin
         logic [31:0] a;
         a = ((32'h100 + $urandom_range(0, 7)) << 2) | $urandom_range(0, 3)
             | ($urandom_range(0, 15) << 19);
         access(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom, 0, rd);
      end

      acc16(1, 32'h14, 2'b11, 16'hBEEF, rd16, lat);
      chk("x_wr_latency", lat, 5);
      acc16(0, 32'h14, 2'b00, 16'h0, rd16, lat);
      chk("x_rd_latency", lat, 3);
      chk("x_rd_beef", rd16, 16'hBEEF);
      acc16(1, 32'h14, 2'b01, 16'h0033, rd16, lat);
      acc16(0, 32'h815, 2'b00, 16'h0, rd16, lat);
      chk("x_rd_alias_byte", rd16, 16'hBE33);

      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
